// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-style control FSM.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StRst      = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAddr  = 4'd3,
    StMemRd    = 4'd4,
    StMemWb    = 4'd5,
    StMemWr    = 4'd6,
    StRExec    = 4'd7,
    StRWb      = 4'd8,
    StBranch   = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11,
    StJump     = 4'd12,
    StJr       = 4'd13
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] FunctJr = 6'b001000;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluRType = 2'b10;
  localparam logic [1:0] AluAddi  = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;
  localparam logic [1:0] PcRs     = 2'b11;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBShift = 2'b11;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OpRType, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpJ: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_out.sv
// Moore output decode: current state (plus opcode and memory ready) to datapath controls.
module mc_ctrl_out
  import mc_ctrl_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        ir_write_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        iord_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic        branch_ne_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  pc_src_o,
  output logic        instr_done_o,
  output logic        illegal_o
);

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    iord_o          = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    alu_src_a_o     = 1'b0;
    branch_ne_o     = 1'b0;
    alu_src_b_o     = SrcBReg;
    alu_op_o        = AluAdd;
    pc_src_o        = PcAlu;
    instr_done_o    = 1'b0;
    illegal_o       = 1'b0;
    case (state_i)
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SrcBFour;
        // IR and PC only latch once the fetched word is actually present.
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      StDecode: begin
        alu_src_b_o = SrcBShift;
        if (!op_legal(opcode_i)) begin
          illegal_o    = 1'b1;
          instr_done_o = 1'b1;
        end
      end
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
      end
      StMemRd: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      StMemWb: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      StMemWr: begin
        mem_write_o  = 1'b1;
        iord_o       = 1'b1;
        instr_done_o = mem_ready_i;
      end
      StRExec: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = AluRType;
      end
      StRWb: begin
        reg_dst_o    = 1'b1;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      StBranch: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = AluSub;
        pc_write_cond_o = 1'b1;
        pc_src_o        = PcAluOut;
        branch_ne_o     = (opcode_i == OpBne);
        instr_done_o    = 1'b1;
      end
      StAddiExec: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SrcBImm;
        alu_op_o    = AluAddi;
      end
      StAddiWb: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      StJump: begin
        pc_write_o   = 1'b1;
        pc_src_o     = PcJump;
        instr_done_o = 1'b1;
      end
      StJr: begin
        pc_write_o   = 1'b1;
        pc_src_o     = PcRs;
        instr_done_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: state register and next-state logic; outputs come from mc_ctrl_out.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        ir_write_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        iord_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic        branch_ne_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  pc_src_o,
  output logic        instr_done_o,
  output logic        illegal_o,
  output logic [3:0]  state_o
);

  state_e r_state;
  state_e w_state_next;
  logic   w_mem_ready;

  assign w_mem_ready = MEM_HANDSHAKE ? mem_ready_i : 1'b1;
  assign state_o     = r_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StRst;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StRst:   w_state_next = StFetch;
      StFetch: if (w_mem_ready) w_state_next = StDecode;
      StDecode: begin
        case (opcode_i)
          OpRType:     w_state_next = (funct_i == FunctJr) ? StJr : StRExec;
          OpLw, OpSw:  w_state_next = StMemAddr;
          OpBeq, OpBne: w_state_next = StBranch;
          OpAddi:      w_state_next = StAddiExec;
          OpJ:         w_state_next = StJump;
          default:     w_state_next = StFetch;
        endcase
      end
      // Only lw and sw reach address calculation.
      StMemAddr:  w_state_next = (opcode_i == OpLw) ? StMemRd : StMemWr;
      StMemRd:    if (w_mem_ready) w_state_next = StMemWb;
      StMemWr:    if (w_mem_ready) w_state_next = StFetch;
      StRExec:    w_state_next = StRWb;
      StAddiExec: w_state_next = StAddiWb;
      default:    w_state_next = StFetch;
    endcase
  end

  mc_ctrl_out u_out (
    .state_i         (r_state),
    .opcode_i        (opcode_i),
    .mem_ready_i     (w_mem_ready),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .ir_write_o      (ir_write_o),
    .reg_write_o     (reg_write_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .iord_o          (iord_o),
    .reg_dst_o       (reg_dst_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .alu_src_a_o     (alu_src_a_o),
    .branch_ne_o     (branch_ne_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .pc_src_o        (pc_src_o),
    .instr_done_o    (instr_done_o),
    .illegal_o       (illegal_o)
  );

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle state and control-vector checks for each instruction class.
module tb_mc_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] opcode_i = 6'h00;
  logic [5:0] funct_i = 6'h00;
  logic       mem_ready_i = 1'b1;
  logic       pc_write_o, pc_write_cond_o, ir_write_o, reg_write_o;
  logic       mem_read_o, mem_write_o, iord_o;
  logic       reg_dst_o, mem_to_reg_o, alu_src_a_o, branch_ne_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_src_o;
  logic       instr_done_o, illegal_o;
  logic [3:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  mc_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .opcode_i        (opcode_i),
    .funct_i         (funct_i),
    .mem_ready_i     (mem_ready_i),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .ir_write_o      (ir_write_o),
    .reg_write_o     (reg_write_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .iord_o          (iord_o),
    .reg_dst_o       (reg_dst_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .alu_src_a_o     (alu_src_a_o),
    .branch_ne_o     (branch_ne_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .pc_src_o        (pc_src_o),
    .instr_done_o    (instr_done_o),
    .illegal_o       (illegal_o),
    .state_o         (state_o)
  );

  logic [18:0] ctrl;
  assign ctrl = {pc_write_o, pc_write_cond_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o,
                 iord_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, branch_ne_o, alu_src_b_o,
                 alu_op_o, pc_src_o, instr_done_o, illegal_o};

  localparam logic [18:0] C_PCW  = 19'h40000;
  localparam logic [18:0] C_PWC  = 19'h20000;
  localparam logic [18:0] C_IRW  = 19'h10000;
  localparam logic [18:0] C_RW   = 19'h08000;
  localparam logic [18:0] C_MR   = 19'h04000;
  localparam logic [18:0] C_MW   = 19'h02000;
  localparam logic [18:0] C_IORD = 19'h01000;
  localparam logic [18:0] C_RDST = 19'h00800;
  localparam logic [18:0] C_MTR  = 19'h00400;
  localparam logic [18:0] C_SRCA = 19'h00200;
  localparam logic [18:0] C_BNE  = 19'h00100;
  localparam logic [18:0] C_B4   = 19'h00040;
  localparam logic [18:0] C_BIMM = 19'h00080;
  localparam logic [18:0] C_BSH  = 19'h000C0;
  localparam logic [18:0] C_SUB  = 19'h00010;
  localparam logic [18:0] C_OPR  = 19'h00020;
  localparam logic [18:0] C_OPI  = 19'h00030;
  localparam logic [18:0] C_PAO  = 19'h00004;
  localparam logic [18:0] C_PJ   = 19'h00008;
  localparam logic [18:0] C_PRS  = 19'h0000C;
  localparam logic [18:0] C_DONE = 19'h00002;
  localparam logic [18:0] C_ILL  = 19'h00001;

  localparam logic [18:0] E_FETCH = C_MR | C_B4 | C_IRW | C_PCW;
  localparam logic [18:0] E_FWAIT = C_MR | C_B4;
  localparam logic [18:0] E_DEC   = C_BSH;
  localparam logic [18:0] E_MADDR = C_SRCA | C_BIMM;
  localparam logic [18:0] E_BR    = C_SRCA | C_SUB | C_PWC | C_PAO | C_DONE;

  localparam logic [3:0] S_RST = 4'd0, S_F = 4'd1, S_D = 4'd2, S_MA = 4'd3, S_MRD = 4'd4;
  localparam logic [3:0] S_MWB = 4'd5, S_MWR = 4'd6, S_RX = 4'd7, S_RWB = 4'd8, S_BR = 4'd9;
  localparam logic [3:0] S_AX = 4'd10, S_AWB = 4'd11, S_J = 4'd12, S_JR = 4'd13;

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp += 2;
    if (state_o !== S_RST) begin
      n_bad++;
      $display("FAIL reset_state got=%0d want=%0d", state_o, S_RST);
    end
    if (ctrl !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_ctrl got=%h want=%h", ctrl, 19'h0);
    end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    n_cmp++;
    if (state_o !== S_F) begin
      n_bad++;
      $display("FAIL reset_exit got=%0d want=%0d", state_o, S_F);
    end
  endtask

  task automatic test_lw();
    logic [3:0]  es [5];
    logic [18:0] ec [5];
    es = '{S_F, S_D, S_MA, S_MRD, S_MWB};
    ec = '{E_FETCH, E_DEC, E_MADDR, C_MR | C_IORD, C_MTR | C_RW | C_DONE};
    opcode_i = 6'h23;
    mem_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp += 2;
      if (state_o !== es[i]) begin
        n_bad++;
        $display("FAIL lw_state cyc%0d got=%0d want=%0d", i, state_o, es[i]);
      end
      if (ctrl !== ec[i]) begin
        n_bad++;
        $display("FAIL lw_ctrl cyc%0d got=%h want=%h", i, ctrl, ec[i]);
      end
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0]  es [7];
    logic [18:0] ec [7];
    logic        rd [7];
    es = '{S_F, S_D, S_MA, S_MWR, S_MWR, S_MWR, S_MWR};
    ec = '{E_FETCH, E_DEC, E_MADDR, C_MW | C_IORD, C_MW | C_IORD, C_MW | C_IORD,
           C_MW | C_IORD | C_DONE};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    opcode_i = 6'h2B;
    for (int i = 0; i < 7; i++) begin
      mem_ready_i = rd[i];
      #1;
      n_cmp += 2;
      if (state_o !== es[i]) begin
        n_bad++;
        $display("FAIL sw_state cyc%0d got=%0d want=%0d", i, state_o, es[i]);
      end
      if (ctrl !== ec[i]) begin
        n_bad++;
        $display("FAIL sw_ctrl cyc%0d got=%h want=%h", i, ctrl, ec[i]);
      end
      @(posedge clk_i);
      #1;
    end
    mem_ready_i = 1'b1;
  endtask

  task automatic test_branch();
    logic [3:0]  es [6];
    logic [18:0] ec [6];
    logic [5:0]  op [6];
    es = '{S_F, S_D, S_BR, S_F, S_D, S_BR};
    ec = '{E_FETCH, E_DEC, E_BR | C_BNE, E_FETCH, E_DEC, E_BR};
    op = '{6'h05, 6'h05, 6'h05, 6'h04, 6'h04, 6'h04};
    for (int i = 0; i < 6; i++) begin
      opcode_i = op[i];
      #1;
      n_cmp += 2;
      if (state_o !== es[i]) begin
        n_bad++;
        $display("FAIL br_state cyc%0d got=%0d want=%0d", i, state_o, es[i]);
      end
      if (ctrl !== ec[i]) begin
        n_bad++;
        $display("FAIL br_ctrl cyc%0d got=%h want=%h", i, ctrl, ec[i]);
      end
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_rtype_jr();
    logic [3:0]  es [7];
    logic [18:0] ec [7];
    logic [5:0]  fn [7];
    es = '{S_F, S_D, S_JR, S_F, S_D, S_RX, S_RWB};
    ec = '{E_FETCH, E_DEC, C_PCW | C_PRS | C_DONE, E_FETCH, E_DEC, C_SRCA | C_OPR,
           C_RDST | C_RW | C_DONE};
    fn = '{6'h08, 6'h08, 6'h08, 6'h20, 6'h20, 6'h20, 6'h20};
    opcode_i = 6'h00;
    for (int i = 0; i < 7; i++) begin
      funct_i = fn[i];
      #1;
      n_cmp += 2;
      if (state_o !== es[i]) begin
        n_bad++;
        $display("FAIL rtype_state cyc%0d got=%0d want=%0d", i, state_o, es[i]);
      end
      if (ctrl !== ec[i]) begin
        n_bad++;
        $display("FAIL rtype_ctrl cyc%0d got=%h want=%h", i, ctrl, ec[i]);
      end
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_addi_fetch_wait();
    logic [3:0]  es [5];
    logic [18:0] ec [5];
    logic        rd [5];
    es = '{S_F, S_F, S_D, S_AX, S_AWB};
    ec = '{E_FWAIT, E_FETCH, E_DEC, C_SRCA | C_BIMM | C_OPI, C_RW | C_DONE};
    rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode_i = 6'h08;
    for (int i = 0; i < 5; i++) begin
      mem_ready_i = rd[i];
      #1;
      n_cmp += 2;
      if (state_o !== es[i]) begin
        n_bad++;
        $display("FAIL addi_state cyc%0d got=%0d want=%0d", i, state_o, es[i]);
      end
      if (ctrl !== ec[i]) begin
        n_bad++;
        $display("FAIL addi_ctrl cyc%0d got=%h want=%h", i, ctrl, ec[i]);
      end
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_jump_illegal();
    logic [3:0]  es [7];
    logic [18:0] ec [7];
    logic [5:0]  op [7];
    es = '{S_F, S_D, S_J, S_F, S_D, S_F, S_D};
    ec = '{E_FETCH, E_DEC, C_PCW | C_PJ | C_DONE, E_FETCH, E_DEC | C_DONE | C_ILL, E_FETCH,
           E_DEC};
    op = '{6'h02, 6'h02, 6'h02, 6'h3F, 6'h3F, 6'h02, 6'h02};
    for (int i = 0; i < 7; i++) begin
      opcode_i = op[i];
      #1;
      n_cmp += 2;
      if (state_o !== es[i]) begin
        n_bad++;
        $display("FAIL jill_state cyc%0d got=%0d want=%0d", i, state_o, es[i]);
      end
      if (ctrl !== ec[i]) begin
        n_bad++;
        $display("FAIL jill_ctrl cyc%0d got=%h want=%h", i, ctrl, ec[i]);
      end
      @(posedge clk_i);
      #1;
    end
    // Finish the pending jump so the next test starts in FETCH.
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset_mid_read();
    logic [3:0]  es [4];
    logic [18:0] ec [4];
    logic        rd [4];
    es = '{S_F, S_D, S_MA, S_MRD};
    ec = '{E_FETCH, E_DEC, E_MADDR, C_MR | C_IORD};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode_i = 6'h23;
    for (int i = 0; i < 4; i++) begin
      mem_ready_i = rd[i];
      #1;
      n_cmp += 2;
      if (state_o !== es[i]) begin
        n_bad++;
        $display("FAIL rstrd_state cyc%0d got=%0d want=%0d", i, state_o, es[i]);
      end
      if (ctrl !== ec[i]) begin
        n_bad++;
        $display("FAIL rstrd_ctrl cyc%0d got=%h want=%h", i, ctrl, ec[i]);
      end
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b1;
    mem_ready_i = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== S_MRD) begin
      n_bad++;
      $display("FAIL rstrd_wait got=%0d want=%0d", state_o, S_MRD);
    end
    @(posedge clk_i);
    #1;
    n_cmp += 2;
    if (state_o !== S_RST) begin
      n_bad++;
      $display("FAIL rstrd_rst_state got=%0d want=%0d", state_o, S_RST);
    end
    if (ctrl !== 19'h0) begin
      n_bad++;
      $display("FAIL rstrd_rst_ctrl got=%h want=%h", ctrl, 19'h0);
    end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    n_cmp += 2;
    if (state_o !== S_F) begin
      n_bad++;
      $display("FAIL rstrd_fetch_state got=%0d want=%0d", state_o, S_F);
    end
    if (ctrl !== E_FWAIT) begin
      n_bad++;
      $display("FAIL rstrd_fetch_ctrl got=%h want=%h", ctrl, E_FWAIT);
    end
    mem_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch();
    test_rtype_jr();
    test_addi_fetch_wait();
    test_jump_illegal();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter: MEM_HANDSHAKE, default 1, meaning: 1 = wait on mem_ready_i; 0 = mem_ready_i treated as constant 1.
REQ-002 clk_i  in  1  single clock, all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 opcode_i  in  6  instruction opcode from external IR, stable from DECODE onward.
REQ-005 funct_i  in  6  instruction funct field from external IR.
REQ-006 mem_ready_i  in  1  memory access completes in this cycle.
REQ-007 pc_write_o, pc_write_cond_o, ir_write_o, reg_write_o  out  1 each  write enables.
REQ-008 mem_read_o, mem_write_o, iord_o  out  1 each  memory controls; iord_o 0 = PC address, 1 = ALUOut address.
REQ-009 reg_dst_o, mem_to_reg_o, alu_src_a_o, branch_ne_o  out  1 each  datapath mux selects.
REQ-010 alu_src_b_o  out  2  00 = B reg, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
REQ-011 alu_op_o  out  2  00 = add, 01 = sub, 10 = R-type by funct, 11 = addi; feeds the ALU control decoder.
REQ-012 pc_src_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs value.
REQ-013 instr_done_o, illegal_o  out  1 each  single-cycle status pulses.
REQ-014 state_o  out  4  current state encoding, for debug.

Function
REQ-015 The block SHALL be a Moore FSM with states RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, ADDI_EXEC, ADDI_WB, JUMP, JR; outputs not listed for a state SHALL be 0.
REQ-016 RST: all outputs 0; next state is FETCH unconditionally.
REQ-017 FETCH outputs: mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=00, pc_src_o=00.
REQ-018 FETCH handshake: ir_write_o=1 and pc_write_o=1 only while mem_ready_i=1, then go to DECODE; otherwise hold FETCH.
REQ-019 DECODE outputs: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=00 (branch target computation).
REQ-020 DECODE dispatch:
- 000000 with funct 001000 -> JR; other 000000 -> R_EXEC
- 100011 or 101011 -> MEM_ADDR
- 000100 or 000101 -> BRANCH
- 001000 -> ADDI_EXEC
- 000010 -> JUMP
REQ-021 Any other opcode in DECODE: illegal_o=1 and instr_done_o=1 for that cycle, next state FETCH, no register, PC or memory write.
REQ-022 MEM_ADDR: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=00; next state MEM_RD for 100011, MEM_WR for 101011.
REQ-023 MEM_RD: mem_read_o=1, iord_o=1; hold until mem_ready_i=1, then MEM_WB.
REQ-024 MEM_WB: reg_dst_o=0, mem_to_reg_o=1, reg_write_o=1; next state FETCH.
REQ-025 MEM_WR: mem_write_o=1, iord_o=1; hold until mem_ready_i=1, then FETCH.
REQ-026 R_EXEC: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=10; next state R_WB.
REQ-027 R_WB: reg_dst_o=1, mem_to_reg_o=0, reg_write_o=1; next state FETCH.
REQ-028 BRANCH: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=01, pc_write_cond_o=1, pc_src_o=01, branch_ne_o=1 iff opcode_i=000101; next state FETCH.
REQ-029 ADDI_EXEC: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=11, then ADDI_WB.
REQ-030 ADDI_WB: reg_dst_o=0, mem_to_reg_o=0, reg_write_o=1, then FETCH.
REQ-031 JUMP: pc_write_o=1, pc_src_o=10, then FETCH.
REQ-032 JR: pc_write_o=1, pc_src_o=11, then FETCH.
REQ-033 instr_done_o SHALL be 1 in the final cycle of each instruction: MEM_WB, MEM_WR when ready, R_WB, BRANCH, ADDI_WB, JUMP, JR, or the illegal DECODE cycle.
REQ-034 Latency with zero wait states SHALL be: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j/jr 3 cycles; each memory wait cycle adds exactly 1.
REQ-035 mem_read_o and mem_write_o SHALL never be 1 in the same cycle.

Reset
REQ-036 rst_i=1 at a clock edge SHALL force state RST from any state, including mid-wait in MEM_RD or MEM_WR, aborting the instruction with no further writes.
REQ-037 While in RST all outputs SHALL be 0 and state_o=0000; FETCH is entered on the first edge with rst_i=0.

Structure
REQ-038 Package mc_ctrl_pkg SHALL hold the state enumeration (4-bit), opcode/funct constants, alu_op codes and pc_src codes.
REQ-039 One sub-module mc_ctrl_out SHALL map the current state plus the opcode and mem_ready_i to the control outputs, combinationally; mc_ctrl holds the state register and next-state logic.

Verification
REQ-040 lw (100011), mem_ready_i=1 always -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; reg_write_o=1 with mem_to_reg_o=1 in cycle 5; instr_done_o is a single pulse.
REQ-041 sw (101011), mem_ready_i low for 3 cycles in MEM_WR -> mem_write_o high for 4 cycles, then FETCH; reg_write_o never asserts.
REQ-042 bne (000101) -> BRANCH cycle shows pc_write_cond_o=1, branch_ne_o=1, alu_op_o=01, pc_src_o=01.
REQ-043 R-type funct 001000 -> JR with pc_src_o=11; funct 100000 -> R_EXEC then R_WB with alu_op_o=10, reg_dst_o=1.
REQ-044 opcode 111111 -> illegal_o=1 in DECODE, return to FETCH, no write enables asserted.
REQ-045 rst_i=1 while in MEM_RD with mem_ready_i=0 -> next cycle state RST, all outputs 0, then FETCH.
